remote_cmd_sender: RTL

//  Remote-side command originator for the quadcopter link. Accepts one

---
 rtl/remote_cmd_sender_if.sv | 29 ++
 rtl/remote_cmd_sender.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/remote_cmd_sender_if.sv
// Signal bundle between remote_cmd_sender and its environment: command
// request/status from the controller side plus the UART transmitter/receiver handshakes.
interface remote_cmd_sender_if;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        busy;
    logic [7:0]  resp;
    logic        resp_rdy;
    logic        cmd_cmplt;
    logic        ack;
    logic        tmo_err;

    modport master (
        input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
        output tx_data, trmt, clr_rx_rdy, busy, resp, resp_rdy, cmd_cmplt, ack, tmo_err
    );

    modport slave (
        output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
        input  tx_data, trmt, clr_rx_rdy, busy, resp, resp_rdy, cmd_cmplt, ack, tmo_err
    );
endinterface

// File: rtl/remote_cmd_sender.sv
// Remote-side command originator: sends opcode + 16-bit payload as three UART
// bytes, then waits (with a saturating timeout) for a single response byte.

module remote_cmd_sender_chk (
    input logic clk,
    input logic rst,
    input logic trmt,
    input logic busy,
    input logic resp_rdy,
    input logic cmd_cmplt,
    input logic tmo_err
);
    a_trmt_single : assert property (@(posedge clk) disable iff (rst) trmt |=> !trmt);
    a_trmt_busy   : assert property (@(posedge clk) disable iff (rst) trmt |-> busy);
    a_rdy_single  : assert property (@(posedge clk) disable iff (rst) resp_rdy |=> !resp_rdy);
    a_rdy_cmplt   : assert property (@(posedge clk) disable iff (rst) resp_rdy |-> cmd_cmplt);
    a_status_excl : assert property (@(posedge clk) disable iff (rst) !(cmd_cmplt && tmo_err));
endmodule

module remote_cmd_sender #(
    parameter int         FAST_SIM = 1,
    parameter logic [7:0] ACK_VAL  = 8'hA5
) (
    input  logic                clk,
    input  logic                rst,
    remote_cmd_sender_if.master bus
);
    localparam int TMR_W = (FAST_SIM != 0) ? 9 : 26;
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TX_CMD = 3'd1,
        W_CMD  = 3'd2,
        TX_HI  = 3'd3,
        W_HI   = 3'd4,
        TX_LO  = 3'd5,
        W_LO   = 3'd6,
        W_RESP = 3'd7
    } state_t;

    state_t           state_r, state_s;
    logic [7:0]       cmd_hold_r, cmd_hold_s;
    logic [15:0]      data_hold_r, data_hold_s;
    logic [TMR_W-1:0] timer_r, timer_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             trmt_r, trmt_s;
    logic             clr_rx_rdy_r, clr_rx_rdy_s;
    logic [7:0]       resp_r, resp_s;
    logic             resp_rdy_r, resp_rdy_s;
    logic             cmd_cmplt_r, cmd_cmplt_s;
    logic             ack_r, ack_s;
    logic             tmo_err_r, tmo_err_s;

    // Next-state and next-value logic for every registered output and holding register.
    always_comb begin
        state_s      = state_r;
        cmd_hold_s   = cmd_hold_r;
        data_hold_s  = data_hold_r;
        timer_s      = timer_r;
        tx_data_s    = tx_data_r;
        trmt_s       = 1'b0;
        clr_rx_rdy_s = 1'b0;
        resp_s       = resp_r;
        resp_rdy_s   = 1'b0;
        cmd_cmplt_s  = cmd_cmplt_r;
        ack_s        = ack_r;
        tmo_err_s    = tmo_err_r;

        case (state_r)
            IDLE: begin
                if (bus.snd_cmd) begin
                    cmd_hold_s   = bus.cmd;
                    data_hold_s  = bus.data;
                    clr_rx_rdy_s = 1'b1;
                    cmd_cmplt_s  = 1'b0;
                    ack_s        = 1'b0;
                    tmo_err_s    = 1'b0;
                    state_s      = TX_CMD;
                end else begin
                    state_s = IDLE;
                end
            end
            TX_CMD: begin
                tx_data_s = cmd_hold_r;
                trmt_s    = 1'b1;
                state_s   = W_CMD;
            end
            W_CMD: begin
                if (bus.tx_done) begin
                    state_s = TX_HI;
                end else begin
                    state_s = W_CMD;
                end
            end
            TX_HI: begin
                tx_data_s = data_hold_r[15:8];
                trmt_s    = 1'b1;
                state_s   = W_HI;
            end
            W_HI: begin
                if (bus.tx_done) begin
                    state_s = TX_LO;
                end else begin
                    state_s = W_HI;
                end
            end
            TX_LO: begin
                tx_data_s = data_hold_r[7:0];
                trmt_s    = 1'b1;
                state_s   = W_LO;
            end
            W_LO: begin
                if (bus.tx_done) begin
                    timer_s = TMR_ZERO;
                    state_s = W_RESP;
                end else begin
                    state_s = W_LO;
                end
            end
            W_RESP: begin
                // A byte arriving on the final timer count still beats the timeout.
                if (bus.rx_rdy) begin
                    resp_s       = bus.rx_data;
                    resp_rdy_s   = 1'b1;
                    clr_rx_rdy_s = 1'b1;
                    cmd_cmplt_s  = 1'b1;
                    ack_s        = (bus.rx_data == ACK_VAL);
                    state_s      = IDLE;
                end else if (timer_r == TMR_MAX) begin
                    tmo_err_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    timer_s = timer_r + TMR_ONE;
                    state_s = W_RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Holding registers, response timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_hold_r   <= 8'h00;
            data_hold_r  <= 16'h0000;
            timer_r      <= TMR_ZERO;
            tx_data_r    <= 8'h00;
            trmt_r       <= 1'b0;
            clr_rx_rdy_r <= 1'b0;
            resp_r       <= 8'h00;
            resp_rdy_r   <= 1'b0;
            cmd_cmplt_r  <= 1'b0;
            ack_r        <= 1'b0;
            tmo_err_r    <= 1'b0;
        end else begin
            cmd_hold_r   <= cmd_hold_s;
            data_hold_r  <= data_hold_s;
            timer_r      <= timer_s;
            tx_data_r    <= tx_data_s;
            trmt_r       <= trmt_s;
            clr_rx_rdy_r <= clr_rx_rdy_s;
            resp_r       <= resp_s;
            resp_rdy_r   <= resp_rdy_s;
            cmd_cmplt_r  <= cmd_cmplt_s;
            ack_r        <= ack_s;
            tmo_err_r    <= tmo_err_s;
        end
    end

    assign bus.tx_data    = tx_data_r;
    assign bus.trmt       = trmt_r;
    assign bus.clr_rx_rdy = clr_rx_rdy_r;
    assign bus.busy       = (state_r != IDLE);
    assign bus.resp       = resp_r;
    assign bus.resp_rdy   = resp_rdy_r;
    assign bus.cmd_cmplt  = cmd_cmplt_r;
    assign bus.ack        = ack_r;
    assign bus.tmo_err    = tmo_err_r;

    remote_cmd_sender_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .trmt      (trmt_r),
        .busy      (bus.busy),
        .resp_rdy  (resp_rdy_r),
        .cmd_cmplt (cmd_cmplt_r),
        .tmo_err   (tmo_err_r)
    );
endmodule
